regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 8, number of registers; address width is $clog2(REG_COUNT).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the number of cycles DBG may wait before forced grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports ex_valid/ex_ready, input/output, 1 each, the EX (ALU) write-back handshake.
REQ-007 SHALL have ports ex_addr, ex_be, ex_data, inputs, addr-width/2/REG_WIDTH, the EX target register, byte enables, and data.
REQ-008 SHALL have ports mem_valid, mem_ready, mem_addr, mem_be, mem_data, with the same shape as EX, for load write-back.
REQ-009 SHALL have ports dbg_valid, dbg_ready, dbg_addr, dbg_be, dbg_data, with the same shape, for debug writes.
REQ-010 SHALL have port flush, input, 1, which discards the EX slot.
REQ-011 SHALL have ports wr_en, wr_addr, wr_data, outputs, 2/addr-width/REG_WIDTH, which drive the register-file write port.
REQ-012 SHALL have port busy, output, REG_COUNT, the per-register pending-write scoreboard.
REQ-013 SHALL use the byte-enable encoding bit1 = low half-word and bit0 = high half-word on every *_be input and on wr_en.

Function
REQ-014 SHALL hold exactly one slot (full, addr, be, data) for each requester.
REQ-015 SHALL define x_ready as !x_full, with ex_ready additionally forced low while flush=1.
REQ-016 SHALL load the slot when x_valid&&x_ready at an edge; be=00 is accepted but SHALL NOT load the slot (no-op).
REQ-017 SHALL arbitrate each cycle among full slots by priority MEM > EX > DBG, except as modified by REQ-018 and REQ-019.
REQ-018 SHALL, when MEM and EX are both full with equal addr, grant the slot loaded at the earlier edge; if both loaded at the same edge, EX goes first and MEM last.
REQ-019 SHALL count cycles DBG is full and not granted; at count==STARVE_LIMIT DBG SHALL win, and the counter SHALL clear on DBG grant.
REQ-020 SHALL, on a grant, register the slot contents into wr_en/wr_addr/wr_data at the next edge and clear the granted slot at that same edge.
REQ-021 SHALL drive wr_en=00 in any cycle following an edge with no grant; wr_addr and wr_data SHALL hold their last values.
REQ-022 SHALL give a minimum latency of: accepted at edge E0, granted in the cycle after E0, wr_en valid after E1, register file commits at E2.
REQ-023 SHALL issue at most one write per cycle, so sustained throughput is 1 write/cycle.
REQ-024 SHALL NOT allow a slot cleared at an edge to be reloaded at that same edge (ready is registered-full based).
REQ-025 SHALL, on flush=1 at an edge, clear the EX slot without issuing it; if EX is granted in that cycle, flush wins and no write results.
REQ-026 SHALL compute busy[r] = OR over full slots with addr==r, OR output-stage wr_en!=0 with wr_addr==r.
REQ-027 SHALL treat writes to register REG_COUNT-1 (PC) identically; it carries no special priority.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear all slots, wr_en=00, wr_addr=0, wr_data=0, busy=0, and starvation counter=0.
REQ-029 SHALL force all x_ready low while rst=1 and high in the first cycle after deassertion.
REQ-030 SHALL discard pending slots on reset mid-operation and produce no partial or late write after deassertion.

Verification
REQ-031 Single EX: ex_addr=3, be=11, data=0xBEEF accepted at E0 -> wr_en=11, wr_addr=3, wr_data=0xBEEF during the cycle after E1; busy[3]=1 from E0 to E2.
REQ-032 Same-edge MEM (r2, 0x1111) and EX (r2, 0x2222) -> EX write first, MEM next cycle; final register r2=0x1111.
REQ-033 Continuous MEM/EX traffic with DBG (r5, 0x00AA, be=10) full -> DBG granted after exactly 4 waiting cycles, with wr_en=10.
REQ-034 EX slot full plus flush=1 -> no write issued for EX, ex_ready=0 during flush, busy bit for that address cleared.
REQ-035 rst pulsed while all three slots are full and the output stage is active -> wr_en=00 immediately, busy=0, and no writes after release.
REQ-036 ex_valid with be=00 -> ex_ready stays 1, slot stays empty, no wr_en pulse.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - three-source register-file write-back arbiter
//
// Collects register write-backs from three requesters and issues at most one
// write per cycle to the register-file write port.
//   EX  (ALU results)    : ex_valid/ex_ready, ex_addr, ex_be, ex_data
//   MEM (load results)   : mem_valid/mem_ready, mem_addr, mem_be, mem_data
//   DBG (debug writes)   : dbg_valid/dbg_ready, dbg_addr, dbg_be, dbg_data
//   flush                : discards the EX slot
//   wr_en/wr_addr/wr_data: registered write port (wr_en is a byte-enable pair)
//   busy                 : per-register pending-write scoreboard
// Byte enables: bit1 = low half-word, bit0 = high half-word.
// Each requester owns one slot. Priority is MEM > EX > DBG, except that
// MEM/EX writes to the same register issue in load order, and a starved
// DBG slot is forced through after STARVE_LIMIT lost cycles.

module regfile_wb_arbiter #(
  parameter int REG_WIDTH    = 16,
  parameter int REG_COUNT    = 8,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [AW-1:0]        ex_addr,
  input  logic [1:0]           ex_be,
  input  logic [REG_WIDTH-1:0] ex_data,

  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [AW-1:0]        mem_addr,
  input  logic [1:0]           mem_be,
  input  logic [REG_WIDTH-1:0] mem_data,

  input  logic                 dbg_valid,
  output logic                 dbg_ready,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [1:0]           dbg_be,
  input  logic [REG_WIDTH-1:0] dbg_data,

  input  logic                 flush,

  output logic [1:0]           wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [REG_WIDTH-1:0] wr_data,

  output logic [REG_COUNT-1:0] busy
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  // Slot storage
  logic                 ex_full, mem_full, dbg_full;
  logic [AW-1:0]        ex_slot_addr, mem_slot_addr, dbg_slot_addr;
  logic [1:0]           ex_slot_be, mem_slot_be, dbg_slot_be;
  logic [REG_WIDTH-1:0] ex_slot_data, mem_slot_data, dbg_slot_data;

  // Set when the EX slot was loaded at an earlier (or the same) edge as the
  // MEM slot; only consulted when both are full and target the same register.
  logic                 ex_first;
  logic [CW-1:0]        dbg_cnt;

  logic                 grant_ex, grant_mem, grant_dbg;
  logic                 issue;
  logic [AW-1:0]        sel_addr;
  logic [1:0]           sel_be;
  logic [REG_WIDTH-1:0] sel_data;
  logic                 ex_load, mem_load, dbg_load;
  logic                 ex_stays, mem_stays;

  // Ready is derived from registered fullness only, so a slot emptied at an
  // edge cannot be refilled at that same edge.
  assign ex_ready  = !rst && !ex_full && !flush;
  assign mem_ready = !rst && !mem_full;
  assign dbg_ready = !rst && !dbg_full;

  // be=00 completes the handshake but is a no-op.
  assign ex_load  = ex_valid  && ex_ready  && (ex_be  != 2'b00);
  assign mem_load = mem_valid && mem_ready && (mem_be != 2'b00);
  assign dbg_load = dbg_valid && dbg_ready && (dbg_be != 2'b00);

  always_comb begin
    grant_ex  = 1'b0;
    grant_mem = 1'b0;
    grant_dbg = 1'b0;
    if (dbg_full && (dbg_cnt == CW'(STARVE_LIMIT))) begin
      grant_dbg = 1'b1;
    end else if (mem_full && ex_full && (mem_slot_addr == ex_slot_addr)) begin
      // Same-register hazard: keep write order, older slot goes first.
      if (ex_first) grant_ex = 1'b1;
      else          grant_mem = 1'b1;
    end else if (mem_full) begin
      grant_mem = 1'b1;
    end else if (ex_full) begin
      grant_ex = 1'b1;
    end else if (dbg_full) begin
      grant_dbg = 1'b1;
    end
  end

  always_comb begin
    sel_addr = ex_slot_addr;
    sel_be   = ex_slot_be;
    sel_data = ex_slot_data;
    if (grant_mem) begin
      sel_addr = mem_slot_addr;
      sel_be   = mem_slot_be;
      sel_data = mem_slot_data;
    end else if (grant_dbg) begin
      sel_addr = dbg_slot_addr;
      sel_be   = dbg_slot_be;
      sel_data = dbg_slot_data;
    end
  end

  // A flushed EX grant is swallowed: the cycle produces no write.
  assign issue = grant_mem || grant_dbg || (grant_ex && !flush);

  assign ex_stays  = ex_full && !grant_ex && !flush;
  assign mem_stays = mem_full && !grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_full       <= 1'b0;
      mem_full      <= 1'b0;
      dbg_full      <= 1'b0;
      ex_slot_addr  <= '0;
      mem_slot_addr <= '0;
      dbg_slot_addr <= '0;
      ex_slot_be    <= '0;
      mem_slot_be   <= '0;
      dbg_slot_be   <= '0;
      ex_slot_data  <= '0;
      mem_slot_data <= '0;
      dbg_slot_data <= '0;
      ex_first      <= 1'b1;
      dbg_cnt       <= '0;
      wr_en         <= 2'b00;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      // EX slot
      if (grant_ex || flush) ex_full <= 1'b0;
      if (ex_load) begin
        ex_full      <= 1'b1;
        ex_slot_addr <= ex_addr;
        ex_slot_be   <= ex_be;
        ex_slot_data <= ex_data;
      end

      // MEM slot
      if (grant_mem) mem_full <= 1'b0;
      if (mem_load) begin
        mem_full      <= 1'b1;
        mem_slot_addr <= mem_addr;
        mem_slot_be   <= mem_be;
        mem_slot_data <= mem_data;
      end

      // DBG slot
      if (grant_dbg) dbg_full <= 1'b0;
      if (dbg_load) begin
        dbg_full      <= 1'b1;
        dbg_slot_addr <= dbg_addr;
        dbg_slot_be   <= dbg_be;
        dbg_slot_data <= dbg_data;
      end

      // Load-order tracking; a same-edge tie favours EX.
      if (ex_load && mem_load)       ex_first <= 1'b1;
      else if (ex_load && mem_stays) ex_first <= 1'b0;
      else if (mem_load && ex_stays) ex_first <= 1'b1;

      // Starvation counter: counts lost cycles while DBG waits.
      if (grant_dbg || !dbg_full) dbg_cnt <= '0;
      else                        dbg_cnt <= dbg_cnt + CW'(1);

      // Output stage: address/data hold when idle.
      if (issue) begin
        wr_en   <= sel_be;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end else begin
        wr_en   <= 2'b00;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if ((ex_full  && (ex_slot_addr  == AW'(r))) ||
          (mem_full && (mem_slot_addr == AW'(r))) ||
          (dbg_full && (dbg_slot_addr == AW'(r))) ||
          ((wr_en != 2'b00) && (wr_addr == AW'(r)))) begin
        busy[r] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_ready;
  logic [AW-1:0] ex_addr;
  logic [1:0]    ex_be;
  logic [W-1:0]  ex_data;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [W-1:0]  mem_data;
  logic          dbg_valid, dbg_ready;
  logic [AW-1:0] dbg_addr;
  logic [1:0]    dbg_be;
  logic [W-1:0]  dbg_data;
  logic          flush;
  logic [1:0]    wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [N-1:0]  busy;

  logic [W-1:0]  rf [N];

  int checks = 0;
  int errors = 0;
  int writes_seen;

  regfile_wb_arbiter #(.REG_WIDTH(W), .REG_COUNT(N), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_be(ex_be), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_be(mem_be), .mem_data(mem_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_be(dbg_be), .dbg_data(dbg_data),
    .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream register file: commits the registered write port.
  always @(posedge clk) begin
    if (wr_en[1]) rf[wr_addr][7:0]  <= wr_data[7:0];
    if (wr_en[0]) rf[wr_addr][15:8] <= wr_data[15:8];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0;  ex_addr = '0;  ex_be = 2'b00;  ex_data = '0;
    mem_valid = 0; mem_addr = '0; mem_be = 2'b00; mem_data = '0;
    dbg_valid = 0; dbg_addr = '0; dbg_be = 2'b00; dbg_data = '0;
    flush = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ex_ready",  ex_ready,  0);
    check_val("rst_mem_ready", mem_ready, 0);
    check_val("rst_dbg_ready", dbg_ready, 0);
    check_val("rst_wr_en",     wr_en,     0);
    check_val("rst_wr_addr",   wr_addr,   0);
    check_val("rst_wr_data",   wr_data,   0);
    check_val("rst_busy",      busy,      0);
    rst = 1'b0;
    #1;
    check_val("rel_ready", {ex_ready, mem_ready, dbg_ready}, 3'b111);

    // Single EX write
    tick();
    ex_valid = 1; ex_addr = 3; ex_be = 2'b11; ex_data = 16'hBEEF;
    tick();
    ex_valid = 0;
    check_val("ex1_busy_e0",  busy,     8'h08);
    check_val("ex1_ready_e0", ex_ready, 0);
    check_val("ex1_wr_en_e0", wr_en,    0);
    tick();
    check_val("ex1_wr_en",   wr_en,   2'b11);
    check_val("ex1_wr_addr", wr_addr, 3);
    check_val("ex1_wr_data", wr_data, 16'hBEEF);
    check_val("ex1_busy_e1", busy,    8'h08);
    tick();
    check_val("ex1_wr_en_e2", wr_en,   0);
    check_val("ex1_busy_e2",  busy,    0);
    check_val("ex1_hold",     wr_data, 16'hBEEF);

    // Same-edge MEM/EX to the same register: EX first, MEM wins finally
    mem_valid = 1; mem_addr = 2; mem_be = 2'b11; mem_data = 16'h1111;
    ex_valid  = 1; ex_addr  = 2; ex_be  = 2'b11; ex_data  = 16'h2222;
    tick();
    idle_inputs();
    check_val("same_busy", busy, 8'h04);
    tick();
    check_val("same_first", wr_data, 16'h2222);
    tick();
    check_val("same_second",    wr_data, 16'h1111);
    check_val("same_second_en", wr_en,   2'b11);
    tick();
    check_val("same_idle", wr_en, 0);
    check_val("same_rf2",  rf[2], 16'h1111);

    // Different registers: plain MEM > EX priority, PC register is ordinary
    mem_valid = 1; mem_addr = 1; mem_be = 2'b11; mem_data = 16'h0101;
    ex_valid  = 1; ex_addr  = 7; ex_be  = 2'b11; ex_data  = 16'h0707;
    tick();
    idle_inputs();
    tick();
    check_val("prio_mem", wr_addr, 1);
    tick();
    check_val("prio_pc_addr", wr_addr, 7);
    check_val("prio_pc_data", wr_data, 16'h0707);
    tick();
    check_val("prio_idle", wr_en, 0);

    // DBG starvation under continuous MEM/EX traffic
    mem_valid = 1; mem_addr = 1; mem_be = 2'b11; mem_data = 16'h1000;
    ex_valid  = 1; ex_addr  = 4; ex_be  = 2'b11; ex_data  = 16'h4000;
    dbg_valid = 1; dbg_addr = 5; dbg_be = 2'b10; dbg_data = 16'h00AA;
    tick();
    dbg_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val($sformatf("starve_wait%0d", i), (wr_addr == 5), 0);
      check_val($sformatf("starve_traffic%0d", i), wr_en, 2'b11);
    end
    tick();
    check_val("starve_en",   wr_en,   2'b10);
    check_val("starve_addr", wr_addr, 5);
    check_val("starve_data", wr_data, 16'h00AA);
    idle_inputs();
    tick();
    check_val("starve_rf5_lo", rf[5][7:0], 8'hAA);
    repeat (4) tick();
    check_val("drain_en",   wr_en, 0);
    check_val("drain_busy", busy,  0);

    // Flush discards a full EX slot
    ex_valid = 1; ex_addr = 6; ex_be = 2'b11; ex_data = 16'h6666;
    tick();
    ex_valid = 0;
    flush = 1;
    #1;
    check_val("flush_ready", ex_ready, 0);
    check_val("flush_busy",  busy,     8'h40);
    tick();
    check_val("flush_no_wr",       wr_en,    0);
    check_val("flush_busy_clr",    busy,     0);
    check_val("flush_ready_empty", ex_ready, 0);
    flush = 0;
    #1;
    check_val("flush_ready_back", ex_ready, 1);
    tick();
    check_val("flush_no_wr2", wr_en, 0);

    // be=00 is a no-op handshake
    ex_valid = 1; ex_addr = 1; ex_be = 2'b00; ex_data = 16'hFFFF;
    tick();
    check_val("be0_ready", ex_ready, 1);
    check_val("be0_busy",  busy,     0);
    ex_valid = 0;
    tick();
    check_val("be0_no_wr", wr_en, 0);
    tick();
    check_val("be0_no_wr2", wr_en, 0);

    // Reset mid-operation with slots full and output stage active
    mem_valid = 1; mem_addr = 1; mem_be = 2'b11; mem_data = 16'hAAAA;
    ex_valid  = 1; ex_addr  = 2; ex_be  = 2'b11; ex_data  = 16'hBBBB;
    dbg_valid = 1; dbg_addr = 3; dbg_be = 2'b11; dbg_data = 16'hCCCC;
    tick();
    idle_inputs();
    check_val("mid_busy_full", busy, 8'h0E);
    tick();
    check_val("mid_active_en", wr_en, 2'b11);
    check_val("mid_active_busy", busy, 8'h0E);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en", wr_en,    0);
    check_val("mid_rst_busy",  busy,     0);
    check_val("mid_rst_ready", ex_ready, 0);
    check_val("mid_rst_data",  wr_data,  0);
    tick();
    rst = 1'b0;
    #1;
    check_val("mid_rel_ready", {ex_ready, mem_ready, dbg_ready}, 3'b111);
    writes_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_en != 2'b00) writes_seen++;
    end
    check_val("mid_no_late_wr", writes_seen, 0);
    check_val("mid_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
